// File: rtl/scope_renderer.sv
// scope_renderer: overlays NUM_CH signed time traces (top half) and one
// unsigned frequency-bar plot (bottom half) on the active video frame.
// Sample RAM is double-buffered; banks swap only at the start of vertical
// blanking, so a displayed frame never mixes old and new samples.
// Optional grid background: define SCOPE_RENDERER_GRID_EN.
module scope_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 1024,
  parameter int SAMPLE_W   = 8,
  parameter int FREQ_DECIM = 3,
  parameter int COLOR_W    = 12
) (
  input  logic                        ckVideo,
  input  logic                        rstN,
  input  logic                        wrEn,
  input  logic [$clog2(NUM_CH+1)-1:0] wrSel,
  input  logic [$clog2(DEPTH)-1:0]    wrAdr,
  input  logic [SAMPLE_W-1:0]         wrData,
  input  logic                        wrCommit,
  output logic                        wrReady,
  output logic                        frameSwapped,
  input  logic                        flgActiveVideo,
  input  logic [9:0]                  adrHor,
  input  logic [9:0]                  adrVer,
  input  logic                        mode,
  input  logic [NUM_CH*COLOR_W-1:0]   traceRGB,
  input  logic [COLOR_W-1:0]          freqRGB,
  output logic [COLOR_W-1:0]          OutputRGB,
  output logic                        flgActiveOut
);

  localparam int SW    = $clog2(NUM_CH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int BASE  = V_ACTIVE / 4;
  localparam int HALF  = V_ACTIVE / 2;
  localparam int FLOOR = V_ACTIVE - 10;

  logic disp;
  logic swap_pending;
  logic swap_point;
  logic wr_ok;

  logic [AW+9:0] hor_ext;
  logic [AW+9:0] fhor_ext;
  logic [AW-1:0] t_idx;
  logic [AW-1:0] f_idx;
  logic          t_oor;
  logic          f_oor;

  logic [(NUM_CH+1)*SAMPLE_W-1:0] rd_flat;

  logic         act_d1;
  logic         mode_d1;
  logic [9:0]   y_d1;
  logic         t_oor_d1;
  logic         f_oor_d1;
`ifdef SCOPE_RENDERER_GRID_EN
  logic [9:0]   x_d1;
`endif

  logic [COLOR_W-1:0] pix;
  logic               hit;
  logic               on;
  int                 yi;
  int                 s;
  int                 t;
  int                 lo;
  int                 hi;
  int                 f;
  int                 top;

  assign swap_point = (adrVer == 10'(V_ACTIVE)) && (adrHor == '0);
  assign wrReady    = ~swap_pending;
  assign wr_ok      = wrEn && ~swap_pending && (wrSel <= SW'(NUM_CH));

  // Read indices: time uses the column directly, frequency a decimated column.
  assign hor_ext  = {{AW{1'b0}}, adrHor};
  assign fhor_ext = hor_ext >> FREQ_DECIM;
  assign t_idx    = hor_ext[AW-1:0];
  assign f_idx    = fhor_ext[AW-1:0];
  assign t_oor    = (hor_ext >= (AW+10)'(DEPTH)) || (hor_ext >= (AW+10)'(H_ACTIVE));
  assign f_oor    = (fhor_ext >= (AW+10)'(DEPTH)) || (hor_ext >= (AW+10)'(H_ACTIVE));

  // Bank control: commit requests a swap, taken at the first line of vblank.
  always_ff @(posedge ckVideo or negedge rstN) begin
    if (!rstN) begin
      disp         <= 1'b0;
      swap_pending <= 1'b0;
      frameSwapped <= 1'b0;
    end else begin
      frameSwapped <= 1'b0;
      if (swap_point && swap_pending) begin
        disp         <= ~disp;
        swap_pending <= 1'b0;
        frameSwapped <= 1'b1;
      end else if (wrCommit) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // One RAM per buffer (time channels, then frequency), bank bit on top of the address.
  for (genvar k = 0; k <= NUM_CH; k++) begin : g_buf
    logic [SAMPLE_W-1:0] ram [2*DEPTH];
    logic [SAMPLE_W-1:0] rd_q;
    logic [AW-1:0]       rd_idx;

    assign rd_idx = (k == NUM_CH) ? f_idx : t_idx;
    assign rd_flat[k*SAMPLE_W +: SAMPLE_W] = rd_q;

    // Back-bank write port and display-bank synchronous read port.
    always_ff @(posedge ckVideo) begin
      if (wr_ok && (wrSel == SW'(k)))
        ram[{~disp, wrAdr}] <= wrData;
      rd_q <= ram[{disp, rd_idx}];
    end
  end

  // Stage 0: carry coordinates and mode alongside the RAM read.
  always_ff @(posedge ckVideo or negedge rstN) begin
    if (!rstN) begin
      act_d1   <= 1'b0;
      mode_d1  <= 1'b0;
      y_d1     <= '0;
      t_oor_d1 <= 1'b0;
      f_oor_d1 <= 1'b0;
`ifdef SCOPE_RENDERER_GRID_EN
      x_d1     <= '0;
`endif
    end else begin
      act_d1   <= flgActiveVideo;
      mode_d1  <= mode;
      y_d1     <= adrVer;
      t_oor_d1 <= t_oor;
      f_oor_d1 <= f_oor;
`ifdef SCOPE_RENDERER_GRID_EN
      x_d1     <= adrHor;
`endif
    end
  end

  // Stage 1 compare: lowest lit channel wins; frequency bar owns the lower half.
  always_comb begin
    pix = '0;
    hit = 1'b0;
    on  = 1'b0;
    yi  = int'(y_d1);
    s   = 0;
    t   = 0;
    lo  = 0;
    hi  = 0;
    f   = 0;
    top = 0;
    if (yi < HALF) begin
      if (!t_oor_d1) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          s = int'($signed(rd_flat[c*SAMPLE_W +: SAMPLE_W]));
          t = BASE - s;
          if (t < 0)        t = 0;
          if (t > HALF - 1) t = HALF - 1;
          lo = (t < BASE) ? t : BASE;
          hi = (t < BASE) ? BASE : t;
          on = mode_d1 ? (yi == t) : ((yi >= lo) && (yi <= hi));
          if (on && !hit) begin
            hit = 1'b1;
            pix = traceRGB[c*COLOR_W +: COLOR_W];
          end
        end
      end
    end else if (!f_oor_d1) begin
      f   = int'(rd_flat[NUM_CH*SAMPLE_W +: SAMPLE_W]);
      top = FLOOR - f;
      if (top < HALF) top = HALF;
      on  = mode_d1 ? (yi == top) : ((yi >= top) && (yi <= FLOOR));
      if (on) begin
        hit = 1'b1;
        pix = freqRGB;
      end
    end
`ifdef SCOPE_RENDERER_GRID_EN
    if (!hit && (((int'(x_d1) % 64) == 0) || ((yi % 60) == 0) || (yi == BASE)))
      pix = COLOR_W'(12'h333);
`endif
  end

  // Output register: blank outside active video.
  always_ff @(posedge ckVideo or negedge rstN) begin
    if (!rstN) begin
      OutputRGB    <= '0;
      flgActiveOut <= 1'b0;
    end else begin
      OutputRGB    <= act_d1 ? pix : '0;
      flgActiveOut <= act_d1;
    end
  end

endmodule

// File: tb/tb_scope_renderer.sv
// Directed bench for scope_renderer with default parameters.
module tb_scope_renderer;

  logic        ckVideo = 1'b0;
  logic        rstN = 1'b0;
  logic        wrEn = 1'b0;
  logic [1:0]  wrSel = '0;
  logic [9:0]  wrAdr = '0;
  logic [7:0]  wrData = '0;
  logic        wrCommit = 1'b0;
  logic        wrReady;
  logic        frameSwapped;
  logic        flgActiveVideo = 1'b0;
  logic [9:0]  adrHor = '0;
  logic [9:0]  adrVer = '0;
  logic        mode = 1'b0;
  logic [23:0] traceRGB = {12'h0F0, 12'hF00};
  logic [11:0] freqRGB = 12'h00F;
  logic [11:0] OutputRGB;
  logic        flgActiveOut;

  int compared = 0;
  int mismatched = 0;

`ifdef SCOPE_RENDERER_GRID_EN
  localparam logic [11:0] GX = 12'h333;
`else
  localparam logic [11:0] GX = 12'h000;
`endif

  scope_renderer #(
    .H_ACTIVE(640), .V_ACTIVE(480), .NUM_CH(2), .DEPTH(1024),
    .SAMPLE_W(8), .FREQ_DECIM(3), .COLOR_W(12)
  ) dut (
    .ckVideo(ckVideo), .rstN(rstN), .wrEn(wrEn), .wrSel(wrSel), .wrAdr(wrAdr),
    .wrData(wrData), .wrCommit(wrCommit), .wrReady(wrReady),
    .frameSwapped(frameSwapped), .flgActiveVideo(flgActiveVideo),
    .adrHor(adrHor), .adrVer(adrVer), .mode(mode), .traceRGB(traceRGB),
    .freqRGB(freqRGB), .OutputRGB(OutputRGB), .flgActiveOut(flgActiveOut)
  );

  always #5 ckVideo = ~ckVideo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic m,
                           input logic [11:0] exp);
    @(negedge ckVideo);
    adrHor = 10'(x);
    adrVer = 10'(y);
    mode = m;
    flgActiveVideo = 1'b1;
    @(posedge ckVideo);
    @(posedge ckVideo);
    #1;
    check(tag, {20'b0, OutputRGB}, {20'b0, exp});
  endtask

  task automatic wr(input logic [1:0] sel, input int adr, input logic [7:0] data);
    @(negedge ckVideo);
    wrEn = 1'b1;
    wrSel = sel;
    wrAdr = 10'(adr);
    wrData = data;
    @(negedge ckVideo);
    wrEn = 1'b0;
  endtask

  task automatic commit();
    @(negedge ckVideo);
    wrCommit = 1'b1;
    @(negedge ckVideo);
    wrCommit = 1'b0;
  endtask

  task automatic init_bank();
    @(negedge ckVideo);
    wrEn = 1'b1;
    wrData = '0;
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 1024; a++) begin
        wrSel = 2'(s);
        wrAdr = 10'(a);
        @(negedge ckVideo);
      end
    end
    wrEn = 1'b0;
  endtask

  // One swap-point cycle; frameSwapped checked one cycle later and the cycle after.
  task automatic swap_cycle(input string tag, input logic cmt, input logic exp_pulse);
    @(negedge ckVideo);
    flgActiveVideo = 1'b0;
    adrVer = 10'd480;
    adrHor = 10'd0;
    wrCommit = cmt;
    @(negedge ckVideo);
    adrVer = 10'd0;
    wrCommit = 1'b0;
    check({tag, "_pulse"}, {31'b0, frameSwapped}, {31'b0, exp_pulse});
    @(negedge ckVideo);
    check({tag, "_after"}, {31'b0, frameSwapped}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_rgb", {20'b0, OutputRGB}, 32'd0);
    check("rst_act", {31'b0, flgActiveOut}, 32'd0);
    check("rst_swp", {31'b0, frameSwapped}, 32'd0);
    check("rst_rdy", {31'b0, wrReady}, 32'd1);
    @(negedge ckVideo);
    rstN = 1'b1;

    // Clear both banks; two swaps bring the display back to bank 0.
    init_bank();
    commit();
    swap_cycle("init_a", 1'b0, 1'b1);
    init_bank();
    commit();
    swap_cycle("init_b", 1'b0, 1'b1);
    check("rdy_after_swap", {31'b0, wrReady}, 32'd1);

    // Empty RAM, bar mode.
    check_pix("e_x0_y120",   0,   120, 1'b0, 12'hF00);
    check_pix("e_x639_y120", 639, 120, 1'b0, 12'hF00);
    check_pix("e_x0_y470",   0,   470, 1'b0, 12'h00F);
    check_pix("e_x300_y470", 300, 470, 1'b0, 12'h00F);
    check_pix("e_x300_y119", 300, 119, 1'b0, 12'h000);
    check_pix("e_x300_y121", 300, 121, 1'b0, 12'h000);
    check_pix("e_x300_y469", 300, 469, 1'b0, 12'h000);
    check_pix("e_x300_y471", 300, 471, 1'b0, 12'h000);

    // Latency: a single active cycle appears exactly two cycles later.
    @(negedge ckVideo);
    flgActiveVideo = 1'b0;
    adrHor = 10'd300;
    adrVer = 10'd120;
    mode = 1'b0;
    repeat (3) @(negedge ckVideo);
    flgActiveVideo = 1'b1;
    @(posedge ckVideo);
    #1;
    check("lat_e1_act", {31'b0, flgActiveOut}, 32'd0);
    @(negedge ckVideo);
    flgActiveVideo = 1'b0;
    @(posedge ckVideo);
    #1;
    check("lat_e2_act", {31'b0, flgActiveOut}, 32'd1);
    check("lat_e2_rgb", {20'b0, OutputRGB}, 32'hF00);
    @(posedge ckVideo);
    #1;
    check("lat_e3_act", {31'b0, flgActiveOut}, 32'd0);
    check("lat_e3_rgb", {20'b0, OutputRGB}, 32'd0);

    // Two channels at x = 10: ch0 = +50 (t=70), ch1 = -20 (t=140).
    wr(2'd0, 10, 8'd50);
    wr(2'd1, 10, 8'hEC);
    commit();
    swap_cycle("swap2", 1'b0, 1'b1);
    check_pix("b_y69",  10, 69,  1'b0, 12'h000);
    check_pix("b_y70",  10, 70,  1'b0, 12'hF00);
    check_pix("b_y120", 10, 120, 1'b0, 12'hF00);
    check_pix("b_y121", 10, 121, 1'b0, 12'h0F0);
    check_pix("b_y140", 10, 140, 1'b0, 12'h0F0);
    check_pix("b_y141", 10, 141, 1'b0, 12'h000);
    check_pix("l_y70",  10, 70,  1'b1, 12'hF00);
    check_pix("l_y140", 10, 140, 1'b1, 12'h0F0);
    check_pix("l_y100", 10, 100, 1'b1, 12'h000);
    check_pix("l_y130", 10, 130, 1'b1, 12'h000);
    check_pix("b_f470", 10, 470, 1'b0, 12'h00F);

    // Frequency bar and clamping.
    wr(2'd2, 5, 8'd200);
    wr(2'd0, 0, 8'h80);
    wr(2'd2, 0, 8'd255);
    commit();
    swap_cycle("swap3", 1'b0, 1'b1);
    check_pix("f_x40_y269", 40, 269, 1'b0, 12'h000);
    check_pix("f_x40_y270", 40, 270, 1'b0, 12'h00F);
    check_pix("f_x40_y470", 40, 470, 1'b0, 12'h00F);
    check_pix("f_x40_y471", 40, 471, 1'b0, 12'h000);
    check_pix("f_x47_y300", 47, 300, 1'b0, 12'h00F);
    check_pix("f_x48_y470", 48, 470, 1'b0, 12'h00F);
    check_pix("f_x48_y469", 48, 469, 1'b0, 12'h000);
    check_pix("c_b_y200",   0,  200, 1'b0, 12'hF00);
    check_pix("c_b_y239",   0,  239, 1'b0, 12'hF00);
    check_pix("c_b_y240",   0,  240, 1'b0, 12'h00F);
    check_pix("c_l_y239",   0,  239, 1'b1, 12'hF00);
    check_pix("c_l_y238",   0,  238, 1'b1, GX);
    check_pix("c_l_y240",   0,  240, 1'b1, 12'h00F);
    check_pix("c_l_y241",   0,  241, 1'b1, GX);
    check_pix("c_l_y120",   0,  120, 1'b1, 12'h0F0);

    // Pending-swap handshake.
    commit();
    check("pend_rdy", {31'b0, wrReady}, 32'd0);
    wr(2'd0, 10, 8'd99);
    commit();
    swap_cycle("swap4", 1'b0, 1'b1);
    check("rdy_after_swap4", {31'b0, wrReady}, 32'd1);
    check_pix("drop_y70", 10, 70, 1'b1, 12'hF00);
    check_pix("drop_y21", 10, 21, 1'b1, 12'h000);
    swap_cycle("noswap", 1'b0, 1'b0);
    check_pix("noswap_y70", 10, 70, 1'b1, 12'hF00);
    swap_cycle("cmt_on_swap", 1'b1, 1'b0);
    check("cmt_on_swap_rdy", {31'b0, wrReady}, 32'd0);
    swap_cycle("deferred", 1'b0, 1'b1);
    check_pix("def_y120", 10, 120, 1'b1, 12'hF00);
    check_pix("def_y70",  10, 70,  1'b1, 12'h000);

    // Reset mid-frame with a pending request.
    check_pix("pre_rst", 10, 120, 1'b1, 12'hF00);
    commit();
    check("pre_rst_rdy", {31'b0, wrReady}, 32'd0);
    repeat (2) @(posedge ckVideo);
    #2;
    check("pre_rst_rgb", {20'b0, OutputRGB}, 32'hF00);
    rstN = 1'b0;
    #1;
    check("mid_rst_rgb", {20'b0, OutputRGB}, 32'd0);
    check("mid_rst_act", {31'b0, flgActiveOut}, 32'd0);
    check("mid_rst_rdy", {31'b0, wrReady}, 32'd1);
    @(negedge ckVideo);
    rstN = 1'b1;
    swap_cycle("rst_discard", 1'b0, 1'b0);

    // Grid corner pixels.
`ifdef SCOPE_RENDERER_GRID_EN
    check_pix("grid_64_61", 64, 61, 1'b0, 12'h333);
`else
    check_pix("grid_64_61", 64, 61, 1'b0, 12'h000);
`endif
    check_pix("grid_65_61", 65, 61, 1'b0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scope_renderer.md
Name: scope_renderer

Overview:
- Parametrised successor to the single-channel time/frequency image controller.
- Renders NUM_CH overlaid signed time traces in the top half of the active frame and one unsigned frequency-bar plot in the bottom half.
- Sample storage is internal, double-buffered and swapped only at the start of vertical blanking, so frames never tear.
- Sits between the sample producers and the VGA output stage, fully in the ckVideo domain; producers cross clock domains upstream.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- NUM_CH, 2: number of time-trace channels (1..4).
- DEPTH, 1024: samples per channel buffer, and entries in the frequency buffer.
- SAMPLE_W, 8: sample width. Time samples are two's complement; frequency samples are unsigned.
- FREQ_DECIM, 3: right-shift applied to adrHor to form the frequency read index.
- COLOR_W, 12: RGB width.

Ports:
- ckVideo  in  1  pixel clock, sole clock.
- rstN  in  1  asynchronous active-low reset.
- wrEn  in  1  write strobe into the back bank.
- wrSel  in  clog2(NUM_CH+1)  buffer select: 0..NUM_CH-1 = time channel, NUM_CH = frequency buffer.
- wrAdr  in  clog2(DEPTH)  sample index.
- wrData  in  SAMPLE_W  sample value.
- wrCommit  in  1  pulse: back bank complete, request swap.
- wrReady  out  1  back bank accepts writes.
- frameSwapped  out  1  one-cycle pulse when the banks swap.
- flgActiveVideo  in  1  active-video flag from the timing generator.
- adrHor  in  10  pixel column.
- adrVer  in  10  pixel line.
- mode  in  1  0 = filled bars, 1 = one-pixel line.
- traceRGB  in  NUM_CH*COLOR_W  per-channel colour; channel c occupies bits [c*COLOR_W +: COLOR_W].
- freqRGB  in  COLOR_W  frequency-bar colour.
- OutputRGB  out  COLOR_W  registered pixel colour.
- flgActiveOut  out  1  flgActiveVideo delayed to align with OutputRGB.

Behaviour:
- Reset (asynchronous, rstN low):
  - OutputRGB = 0, flgActiveOut = 0, frameSwapped = 0.
  - Display bank = 0, swapPending = 0, wrReady = 1.
  - RAM contents are not reset.
- Banks: two copies of (NUM_CH time buffers + 1 frequency buffer). Writes go to bank ~disp; reads come from bank disp.
- Write acceptance:
  - A write is accepted when wrEn = 1, wrReady = 1 and wrSel <= NUM_CH.
  - Any other write is silently dropped.
  - wrReady = ~swapPending.
- Commit:
  - wrCommit while swapPending = 0 sets swapPending.
  - wrCommit while swapPending = 1 has no effect.
- Swap point: the cycle with adrVer == V_ACTIVE and adrHor == 0, with swapPending = 1. That cycle:
  - toggles disp;
  - clears swapPending;
  - pulses frameSwapped the following cycle.
  - If wrCommit arrives on the swap-point cycle with swapPending = 0, it sets pending, and the swap waits for the next frame.
  - Reset mid-pending discards the request.
- Pixel pipeline, latency 2 cycles from adrHor/adrVer/flgActiveVideo to OutputRGB/flgActiveOut:
  - Stage 0: issue synchronous RAM reads. Time index = adrHor. Frequency index = adrHor >> FREQ_DECIM. Register coordinates and mode.
  - Stage 1: compare and register the result.
- Time region, y < V_ACTIVE/2:
  - Baseline B = V_ACTIVE/4.
  - Target row t = B - s, where s is the sign-extended sample, clamped to [0, V_ACTIVE/2 - 1].
  - Bar mode lights y between t and B inclusive, in either direction.
  - Line mode lights y == t only.
  - When several channels hit, the lowest channel index wins.
- Frequency region, y >= V_ACTIVE/2:
  - Floor F = V_ACTIVE - 10.
  - Bar mode lights F - f <= y <= F, where F - f is clamped to >= V_ACTIVE/2.
  - Line mode lights y == max(F - f, V_ACTIVE/2).
- Out-of-range pixels: adrHor >= DEPTH, or (adrHor >> FREQ_DECIM) >= DEPTH for the frequency region, render background.
- Output: if the delayed active flag is 0, OutputRGB = 0; otherwise the lit colour, else background. Background is 0 unless GRID_EN is defined.

Optional Feature:
- Macro: SCOPE_RENDERER_GRID_EN.
- Defined: background pixels become 12'h333 when adrHor % 64 == 0, adrVer % 60 == 0, or y == B. Trace and bar pixels take priority over the grid.
- Undefined: background is always 0, and no grid logic is synthesised.

Test Plan:
- Reset, then one frame with empty RAM (all 0) and mode 0, traceRGB ch0 = 12'hF00 → rows y = 120 and y = 470 lit at every x < 640; all other pixels 0; OutputRGB lags flgActiveVideo by exactly 2 cycles.
- Write ch0[10] = 8'sd50, ch1[10] = -8'sd20, commit, run past the swap → frameSwapped pulses once at line 480. At x = 10: bar mode lights y 70..120 in ch0 colour and 121..140 in ch1 colour; line mode lights y = 70 and y = 140 only.
- Write freq[5] = 200 with FREQ_DECIM = 3 → bottom half at x = 40..47 lit for y 270..470 in freqRGB; at x = 48, only y = 470 is lit.
- Write ch0[0] = -128 → t clamps to 239; write freq = 255 → top row clamps to 240; no lit pixel crosses into the other region.
- Commit, then assert wrEn before the swap → wrReady = 0, write dropped, and the following frame still shows the old value. A second commit while pending causes no second swap; wrCommit on the swap cycle defers the swap to the next frame.
- With SCOPE_RENDERER_GRID_EN and empty RAM (all 0) → pixel (64, 61) = 12'h333, pixel (65, 61) = 0; reset asserted mid-frame drives OutputRGB to 0 immediately.
